hazard_detect: RTL and testbench
================================

# hazard_detect

Hazard detection unit for the 5-stage pipeline. It sits directly upstream of the pipeline control block. It detects load-use data hazards, data-memory wait cycles and the taken-branch shadow, and drives `do_stall` and a global `freeze`, which pipeline control turns into per-register lock/clear patterns. It holds a small FSM for branch-shadow suppression and memory-wait tracking, plus a watchdog on stuck memory waits.

## Interface
Parameters:
- `REG_W`, 5: register-specifier width.
- `WAIT_MAX`, 16: consecutive `mem_busy` cycles before `mem_timeout` sets; legal range 1..2^16-1.
- `CNT_W`, 16: width of statistics counters.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clock`.
- `id_rs`  in  REG_W  rs specifier of the instruction in ID.
- `id_rt`  in  REG_W  rt specifier of the instruction in ID.
- `id_uses_rs`  in  1  ID instruction reads rs.
- `id_uses_rt`  in  1  ID instruction reads rt.
- `ex_rt`  in  REG_W  destination of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `branch`  in  1  taken branch/jump resolved this cycle; same signal pipeline control consumes.
- `mem_busy`  in  1  data memory not ready; the MEM stage must hold.
- `do_stall`  out  1  freeze PC and IF/ID, bubble ID/EX; feeds pipeline control `do_stall`.
- `freeze`  out  1  hold every pipeline register; no bubbles.
- `mem_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`  out  CNT_W  only with macro; load-use stall cycles.
- `wait_cycles`  out  CNT_W  only with macro; `freeze` cycles.

## Operation
- Load-use condition `lu`: `ex_mem_read` and `ex_rt != 0`, and either (`id_uses_rs` and `id_rs == ex_rt`) or (`id_uses_rt` and `id_rt == ex_rt`).
- FSM states:
  - IDLE: reset state.
  - SHADOW: cycle after a taken branch.
  - WAIT: `mem_busy` persisting.
- Transitions are evaluated each edge in priority order `branch` > `mem_busy` > otherwise:
  - Any state with `branch`=1 goes to SHADOW.
  - Any state with `mem_busy`=1 and `branch`=0 goes to WAIT.
  - All other cases go to IDLE.
- `freeze` = `mem_busy`, combinational, in any state.
- `do_stall` = `lu` and not `branch` and not `mem_busy` and state != SHADOW.
  - A branch squashes the ID instruction, so no stall is raised for it.
  - In SHADOW, the ID slot holds a cleared bubble whose specifiers are ignored.
  - `freeze` supersedes the stall.
- Watchdog `wcnt` (16 bits):
  - Increments each cycle `mem_busy`=1, saturating at `WAIT_MAX`.
  - Clears when `mem_busy`=0.
  - `mem_timeout` sets on the edge where `wcnt` reaches `WAIT_MAX`. It stays set until reset.
  - `freeze` keeps following `mem_busy` after timeout.
- Register `$0` never causes a hazard.

## Timing
- Reset values: state=IDLE, `wcnt`=0, `mem_timeout`=0, counters=0. `do_stall` and `freeze` are combinational and show 0 whenever the inputs are inactive.
- Load-use stall lasts exactly 1 cycle: next cycle the load is in MEM, and EX holds a bubble with `ex_mem_read`=0.
- `branch` and `lu` in the same cycle: `do_stall`=0; the next cycle is SHADOW.
- `branch` and `mem_busy` in the same cycle: `freeze`=1, next state SHADOW. Pipeline control applies the clear, and the frozen registers win; the SHADOW suppression covers the first post-branch ID.
- `mem_timeout` rises on edge N when `mem_busy` has been high for N=`WAIT_MAX` consecutive sampled edges.
- Reset asserted mid-WAIT: the next edge clears all state. `freeze` still follows `mem_busy`.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cycles` increments each cycle `do_stall`=1.
  - `wait_cycles` increments each cycle `freeze`=1.
  - Both saturate at all-ones and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package `pipe_pkg`:
  - FSM state encoding `hz_state_t` (IDLE=0, SHADOW=1, WAIT=2).
  - `REG_ZERO` constant.
  - Default `WAIT_MAX`.
- One sub-module, `sat_counter` (width-parameterised, enable, sync clear, saturating). It is used for `wcnt` and both statistics counters.

## Test plan
- Load-use:
  - Stimulus: `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8, `id_uses_rs`=1.
  - Required: `do_stall`=1 that cycle. With EX set to a bubble next cycle, `do_stall`=0; `stall_cycles`=1 when the macro is defined.
- `$0` exclusion:
  - Stimulus: same as load-use but `ex_rt`=0 and `id_rs`=0.
  - Required: `do_stall`=0.
- Branch precedence:
  - Stimulus: `lu` condition and `branch`=1 in the same cycle.
  - Required: `do_stall`=0. The next cycle is SHADOW with `do_stall`=0 even though `lu` is held.
- Memory wait:
  - Stimulus: `mem_busy`=1 for 3 cycles.
  - Required: `freeze`=1 for exactly 3 cycles, `do_stall`=0 throughout, `wait_cycles`=3.
- Watchdog:
  - Stimulus: `WAIT_MAX`=4, `mem_busy` held 4 edges.
  - Required: `mem_timeout`=1 after the 4th edge. It stays 1 after `mem_busy` drops, and clears only after `reset_n`=0 for one edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, the hardwired-zero
// register specifier and the default memory-wait watchdog limit.
package pipe_pkg;

   typedef enum logic [1:0] {
      HZ_IDLE   = 2'd0,
      HZ_SHADOW = 2'd1,
      HZ_WAIT   = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_ZERO     = 5'd0;
   localparam int         WAIT_MAX_DEF = 16;

endpackage

// File: rtl/hazard_detect_sat_counter.sv
// sat_counter: width-parameterised up-counter with enable, synchronous
// clear and saturation at MAX. Reset is synchronous, active-low.
module sat_counter #(
   parameter int           W   = 16,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   // clear wins over enable; hold once MAX is reached
   always_ff @(posedge clock) begin
      if (!reset_n || clr) begin
         q <= '0;
      end else if (en && (q != MAX)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/hazard_detect.sv
// hazard_detect: load-use / memory-wait / branch-shadow hazard unit feeding
// pipeline control. Optional statistics counters are built only when the
// HAZARD_STATS_EN macro is defined; otherwise the stats ports read 0.
//
// state     | meaning
// ----------+------------------------------------------------------------
// HZ_IDLE   | reset state, no branch or memory wait seen last edge
// HZ_SHADOW | cycle after a taken branch; ID holds a squashed bubble
// HZ_WAIT   | mem_busy persisted across the last edge
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int WAIT_MAX = WAIT_MAX_DEF,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_mem_read,
   input  logic             branch,
   input  logic             mem_busy,
   output logic             do_stall,
   output logic             freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] wait_cycles
);

   hz_state_t   state;
   hz_state_t   state_nxt;
   logic        lu;
   logic [15:0] wcnt;

   // load-use: a load in EX writes a non-zero register the ID instruction reads
   always_comb begin
      lu = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
           ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
   end

   // state register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= HZ_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state (branch beats mem_busy) and hazard outputs
   always_comb begin
      state_nxt = HZ_IDLE;
      freeze    = mem_busy;
      do_stall  = 1'b0;
      if (branch) begin
         state_nxt = HZ_SHADOW;
      end else if (mem_busy) begin
         state_nxt = HZ_WAIT;
      end
      // a squashed ID (branch now or in the shadow) never stalls; freeze supersedes
      if (lu && !branch && !mem_busy && (state != HZ_SHADOW)) begin
         do_stall = 1'b1;
      end
   end

   sat_counter #(
      .W   (16),
      .MAX (16'(WAIT_MAX))
   ) u_wcnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (!mem_busy),
      .en      (mem_busy),
      .q       (wcnt)
   );

   // sticky watchdog: set on the edge where wcnt steps onto WAIT_MAX
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mem_timeout <= 1'b0;
      end else if (mem_busy && (wcnt == 16'(WAIT_MAX - 1))) begin
         mem_timeout <= 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (1'b0),
      .en      (do_stall),
      .q       (stall_cycles)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_wait_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (1'b0),
      .en      (freeze),
      .q       (wait_cycles)
   );
`else
   assign stall_cycles = '0;
   assign wait_cycles  = '0;
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect with a behavioural model checked every
// cycle plus literal expectations at the interesting points.
module tb_hazard_detect;

   localparam int REG_W    = 5;
   localparam int WAIT_MAX = 4;
   localparam int CNT_W    = 16;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [REG_W-1:0] id_rs = '0;
   logic [REG_W-1:0] id_rt = '0;
   logic             id_uses_rs = 1'b0;
   logic             id_uses_rt = 1'b0;
   logic [REG_W-1:0] ex_rt = '0;
   logic             ex_mem_read = 1'b0;
   logic             branch = 1'b0;
   logic             mem_busy = 1'b0;
   logic             do_stall;
   logic             freeze;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] wait_cycles;

   hazard_detect #(
      .REG_W    (REG_W),
      .WAIT_MAX (WAIT_MAX),
      .CNT_W    (CNT_W)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .ex_rt        (ex_rt),
      .ex_mem_read  (ex_mem_read),
      .branch       (branch),
      .mem_busy     (mem_busy),
      .do_stall     (do_stall),
      .freeze       (freeze),
      .mem_timeout  (mem_timeout),
      .stall_cycles (stall_cycles),
      .wait_cycles  (wait_cycles)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   bit mon_on = 1'b0;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // model state: was the previous edge a branch, busy run length, sticky timeout, counts
   bit m_after_branch = 1'b0;
   int m_run = 0;
   bit m_to = 1'b0;
   int m_stalls = 0;
   int m_waits = 0;

   function automatic bit reads_reg(int r);
      return (id_uses_rs && int'(id_rs) == r) || (id_uses_rt && int'(id_rt) == r);
   endfunction

   function automatic bit exp_stall();
      bit load_use;
      load_use = ex_mem_read && int'(ex_rt) != 0 && reads_reg(int'(ex_rt));
      return load_use && !branch && !mem_busy && !m_after_branch;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      if (!reset_n) begin
         m_after_branch <= 1'b0;
         m_run          <= 0;
         m_to           <= 1'b0;
         m_stalls       <= 0;
         m_waits        <= 0;
      end else begin
         m_after_branch <= branch;
         if (mem_busy) begin
            m_run <= (m_run < WAIT_MAX) ? m_run + 1 : m_run;
            if (m_run + 1 >= WAIT_MAX) m_to <= 1'b1;
            if (m_waits < CNT_MAX) m_waits <= m_waits + 1;
         end else begin
            m_run <= 0;
         end
         if (exp_stall() && m_stalls < CNT_MAX) m_stalls <= m_stalls + 1;
      end
   end

   always @(negedge clock) begin
      if (mon_on) begin
         check("do_stall", int'(do_stall), int'(exp_stall()));
         check("freeze", int'(freeze), int'(mem_busy));
         check("mem_timeout", int'(mem_timeout), int'(m_to));
         check("stall_cycles", int'(stall_cycles), STATS ? m_stalls : 0);
         check("wait_cycles", int'(wait_cycles), STATS ? m_waits : 0);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ex(input bit rd, input int rt);
      ex_mem_read = rd;
      ex_rt       = REG_W'(rt);
   endtask

   task automatic set_id(input int rs, input bit urs, input int rt, input bit urt);
      id_rs      = REG_W'(rs);
      id_uses_rs = urs;
      id_rt      = REG_W'(rt);
      id_uses_rt = urt;
   endtask

   int base_w;

   initial begin
      // reset
      step();
      mon_on = 1'b1;
      step();
      check("rst_do_stall", int'(do_stall), 0);
      check("rst_freeze", int'(freeze), 0);
      check("rst_timeout", int'(mem_timeout), 0);
      reset_n = 1'b1;
      step();

      // load-use on rs, then EX bubble
      set_ex(1, 8); set_id(8, 1, 0, 0);
      #1 check("lu_rs", int'(do_stall), 1);
      step();
      set_ex(0, 0);
      #1 check("lu_bubble", int'(do_stall), 0);
      check("lu_stall_cnt", int'(stall_cycles), STATS ? 1 : 0);
      step();

      // $0 never hazards
      set_ex(1, 0); set_id(0, 1, 0, 1);
      #1 check("reg_zero", int'(do_stall), 0);
      step();

      // load-use on rt only, then rt not used
      set_ex(1, 9); set_id(3, 1, 9, 1);
      #1 check("lu_rt", int'(do_stall), 1);
      step();
      id_uses_rt = 1'b0;
      #1 check("rt_unused", int'(do_stall), 0);
      step();

      // branch precedence and shadow
      set_ex(1, 12); set_id(12, 1, 0, 0); branch = 1'b1;
      #1 check("br_same_cycle", int'(do_stall), 0);
      step();
      branch = 1'b0;
      #1 check("br_shadow", int'(do_stall), 0);
      step();
      #1 check("br_after_shadow", int'(do_stall), 1);
      step();
      set_ex(0, 0);
      step();

      // 3-cycle memory wait with lu held
      base_w = int'(wait_cycles);
      set_ex(1, 5); set_id(5, 1, 0, 0);
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("mw_freeze", int'(freeze), 1);
         check("mw_no_stall", int'(do_stall), 0);
         step();
      end
      mem_busy = 1'b0;
      set_ex(0, 0);
      #1 check("mw_release", int'(freeze), 0);
      check("mw_wait_cnt", int'(wait_cycles) - base_w, STATS ? 3 : 0);
      check("mw_no_timeout", int'(mem_timeout), 0);
      step();

      // branch together with mem_busy
      branch = 1'b1; mem_busy = 1'b1;
      #1 check("brmw_freeze", int'(freeze), 1);
      step();
      branch = 1'b0; mem_busy = 1'b0;
      set_ex(1, 7); set_id(0, 0, 7, 1);
      #1 check("brmw_shadow", int'(do_stall), 0);
      step();
      set_ex(0, 0);
      step();

      // watchdog: mem_busy held for WAIT_MAX edges
      mem_busy = 1'b1;
      for (int i = 1; i <= WAIT_MAX; i++) begin
         step();
         check("wd_edge", int'(mem_timeout), (i == WAIT_MAX) ? 1 : 0);
      end
      step();
      mem_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("wd_sticky", int'(mem_timeout), 1);
      end

      // reset mid-wait
      mem_busy = 1'b1;
      step();
      reset_n = 1'b0;
      #1 check("rst_freeze_follows", int'(freeze), 1);
      step();
      check("wd_cleared", int'(mem_timeout), 0);
      check("stats_cleared", int'(stall_cycles) + int'(wait_cycles), 0);
      reset_n = 1'b1;
      mem_busy = 1'b0;
      step();
      step();

      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
